dfx_pkt_encap: RTL and testbench
================================

# dfx_pkt_encap

Packet encapsulator that sits directly upstream of router input port 0. It turns a raw DFX payload stream, read out of local memory after an arbiter read grant, into one framed Aurora packet. The packet is a header word, then PAYLOAD_WORDS payload words, then an optional tail word, written into the input-port-0 FIFO. It requests each packet header from the router controller through the ready_encap_dfx / header_pkt_send handshake.

## Interface
- AURORA_DATA_WIDTH, 64, FIFO word width
- ADDR_WIDTH, 10, destination address width
- PAYLOAD_WORDS, 16, payload words per packet (1..65535)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- dfx_start  in  1  request to frame one packet; sampled only in IDLE
- ready_encap_dfx  out  1  one-cycle pulse requesting the next header from the controller
- header_pkt_send  in  9  {TTL[8:7], pkt_num[6:2], src_router[1:0]}
- router_dst_addr_send  in  ADDR_WIDTH  destination address for this packet
- payload_valid  in  1  payload word available
- payload_data  in  AURORA_DATA_WIDTH  payload word
- payload_ready  out  1  payload word accepted this cycle (combinational)
- fifo_almost_full  in  1  input-port-0 FIFO has at most 1 free slot
- wr_input_port_0  out  1  FIFO write strobe (registered)
- data_input_port_0  out  AURORA_DATA_WIDTH  FIFO write data (registered)
- encap_busy  out  1  high in every state except IDLE
- pkt_done  out  1  one-cycle pulse after the last word of a packet is written

## Operation
- FSM states: IDLE, REQ, LATCH, HDR, PAY, TAIL, DONE.
- IDLE: when dfx_start=1, go to REQ. A dfx_start while busy is ignored, not queued.
- REQ: ready_encap_dfx=1 for exactly this cycle, then go to LATCH. The controller registers new header fields on the next edge.
- LATCH: capture header_pkt_send and router_dst_addr_send into internal registers, then go to HDR.
- HDR: when fifo_almost_full=0, write the header word and go to PAY. Otherwise stall in HDR.
- Header word bit layout:
  - [8:0] captured header
  - [ADDR_WIDTH+8:9] captured destination address
  - [47:32] PAYLOAD_WORDS
  - all other bits 0
- PAY: payload_ready = payload_valid & ~fifo_almost_full. Each accepted word is written unchanged and increments word_cnt. This word_cnt width is the bit width of PAYLOAD_WORDS.
- After the accepted word that brings word_cnt to PAYLOAD_WORDS: go to TAIL if DFX_ENCAP_TAIL_EN is defined, otherwise to DONE.
- TAIL: when fifo_almost_full=0, write the tail word and go to DONE.
- DONE: pkt_done=1 for one cycle, clear word_cnt, go to IDLE.
- The block never modifies the TTL field. TTL decrement belongs to the router controller.

## Timing
- Reset value of every output is 0. Internal header registers, word_cnt, and checksum reset to 0. State resets to IDLE.
- Reset asserted mid-packet aborts the packet: state returns to IDLE and no further words are written. Any partial packet already written stays in the FIFO; clearing it is the system's responsibility.
- Latency from dfx_start to header write is 4 clock edges: IDLE→REQ→LATCH→HDR, then wr_input_port_0 high one cycle later. Minimum time from dfx_start to the wr_input_port_0 header pulse is 4 cycles.
- Each FIFO write appears on wr_input_port_0 and data_input_port_0 in the cycle after its handshake.
  - wr_input_port_0 is high for exactly one cycle per word.
  - data_input_port_0 holds its last value when wr_input_port_0=0.
- Because of this one-cycle registered lag, the FIFO must drive fifo_almost_full, not full.
- Throughput: one payload word per cycle when payload_valid=1 and fifo_almost_full=0 continuously.
- payload_valid and fifo_almost_full may toggle on any cycle. A word is consumed only on cycles where payload_ready=1.
- pkt_done is asserted the cycle after the last word's wr_input_port_0 pulse.
- Back-to-back packets: dfx_start held high in DONE→IDLE gives a minimum gap of 5 cycles between a packet's last write and the next header write.

## Configuration
- DFX_ENCAP_TAIL_EN defined:
  - a checksum register XORs every accepted payload word; it clears in LATCH.
  - TAIL writes {checksum[63:9], captured header[8:0]}.
  - A packet is PAYLOAD_WORDS+2 words long.
- Not defined: no TAIL state, no checksum logic, and a packet is PAYLOAD_WORDS+1 words long.

## Structure
- Shared package `router_pkg` holds:
  - header field offsets: TTL_MSB=8, TTL_LSB=7, PKTNUM_MSB=6, PKTNUM_LSB=2, SRC_MSB=1, SRC_LSB=0
  - DST_LSB=9, LEN_LSB=32, LEN_WIDTH=16
  - the FSM state encoding
- One sub-module is natural: `dfx_xor_checksum`, the accumulator with clear and enable. It is instantiated only under DFX_ENCAP_TAIL_EN.

## Test plan
- Reset, then dfx_start pulse with header_pkt_send=9'h10A, dst=10'h155 and FIFO never full. Required:
  - ready_encap_dfx pulses once
  - header word = 64'h0000_0010_0002_AB0A, then 16 payload words in order
  - pkt_done one cycle after the last write
- Toggle fifo_almost_full every other cycle during PAY. Required: no word dropped or duplicated, and exactly 17 writes (18 with TAIL) per packet.
- Pulse dfx_start again during PAY. Required: it is ignored and exactly one packet is produced.
- Assert rst at the 5th payload word. Required: all outputs are 0 the next cycle, no further writes, and the next dfx_start produces a full, correct packet.
- With DFX_ENCAP_TAIL_EN and payload words 1..16. Required: tail[63:9] = XOR of 1..16 ([63:9] = 0), tail[8:0] = header.
- Hold dfx_start high continuously. Required: packets are back-to-back, with one ready_encap_dfx pulse per packet and a 5-cycle inter-packet gap.

Source files
------------

// File: rtl/router_pkg.sv
// Shared router definitions: 9-bit header field offsets, encapsulated word
// layout offsets and the DFX encapsulator FSM state encoding.
package router_pkg;

  localparam int HDR_W      = 9;
  localparam int TTL_MSB    = 8;
  localparam int TTL_LSB    = 7;
  localparam int PKTNUM_MSB = 6;
  localparam int PKTNUM_LSB = 2;
  localparam int SRC_MSB    = 1;
  localparam int SRC_LSB    = 0;

  localparam int DST_LSB    = 9;
  localparam int LEN_LSB    = 32;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LATCH = 3'd2,
    ST_HDR   = 3'd3,
    ST_PAY   = 3'd4,
    ST_TAIL  = 3'd5,
    ST_DONE  = 3'd6
  } encap_state_e;

endpackage

// File: rtl/dfx_xor_checksum.sv
// Running XOR over accepted payload words, with a synchronous clear that
// restarts the accumulation for each packet.
module dfx_xor_checksum #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] sum
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum ^ din;
    end
  end

endmodule

// File: rtl/dfx_pkt_encap.sv
// Frames a DFX payload stream into one Aurora packet (header, payload, optional
// tail) for router input port 0. Tail word is built when DFX_ENCAP_TAIL_EN is defined.
module dfx_pkt_encap
  import router_pkg::*;
#(
  parameter int AURORA_DATA_WIDTH = 64,
  parameter int ADDR_WIDTH        = 10,
  parameter int PAYLOAD_WORDS     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dfx_start,
  output logic                         ready_encap_dfx,
  input  logic [8:0]                   header_pkt_send,
  input  logic [ADDR_WIDTH-1:0]        router_dst_addr_send,
  input  logic                         payload_valid,
  input  logic [AURORA_DATA_WIDTH-1:0] payload_data,
  output logic                         payload_ready,
  input  logic                         fifo_almost_full,
  output logic                         wr_input_port_0,
  output logic [AURORA_DATA_WIDTH-1:0] data_input_port_0,
  output logic                         encap_busy,
  output logic                         pkt_done
);

  localparam int CNT_W = $clog2(PAYLOAD_WORDS + 1);

  encap_state_e                   state;
  logic [HDR_W-1:0]               hdr_cap_p0;
  logic [ADDR_WIDTH-1:0]          dst_cap_p0;
  logic [CNT_W-1:0]               word_cnt;
  logic                           pay_accept;
  logic                           last_word;
  logic [AURORA_DATA_WIDTH-1:0]   hdr_word;

  assign pay_accept    = (state == ST_PAY) && payload_valid && !fifo_almost_full;
  assign payload_ready = pay_accept;
  assign last_word     = (word_cnt == CNT_W'(PAYLOAD_WORDS - 1));

  always_comb begin
    hdr_word                          = '0;
    hdr_word[HDR_W-1:0]               = hdr_cap_p0;
    hdr_word[DST_LSB +: ADDR_WIDTH]   = dst_cap_p0;
    hdr_word[LEN_LSB +: LEN_WIDTH]    = LEN_WIDTH'(PAYLOAD_WORDS);
  end

`ifdef DFX_ENCAP_TAIL_EN
  logic [AURORA_DATA_WIDTH-1:0] csum;
  logic [AURORA_DATA_WIDTH-1:0] tail_word;

  dfx_xor_checksum #(
    .DATA_W (AURORA_DATA_WIDTH)
  ) u_csum (
    .clk (clk),
    .rst (rst),
    .clr (state == ST_LATCH),
    .en  (pay_accept),
    .din (payload_data),
    .sum (csum)
  );

  // Low bits of the checksum are replaced by the header so the tail is self-identifying.
  always_comb begin
    tail_word            = csum;
    tail_word[HDR_W-1:0] = hdr_cap_p0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      ready_encap_dfx   <= 1'b0;
      wr_input_port_0   <= 1'b0;
      data_input_port_0 <= '0;
      encap_busy        <= 1'b0;
      pkt_done          <= 1'b0;
      hdr_cap_p0        <= '0;
      dst_cap_p0        <= '0;
      word_cnt          <= '0;
    end else begin
      ready_encap_dfx <= 1'b0;
      wr_input_port_0 <= 1'b0;
      pkt_done        <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (dfx_start) begin
            state           <= ST_REQ;
            ready_encap_dfx <= 1'b1;
            encap_busy      <= 1'b1;
          end
        end
        ST_REQ: begin
          state <= ST_LATCH;
        end
        // TTL passes through untouched; only the router controller decrements it.
        ST_LATCH: begin
          hdr_cap_p0[TTL_MSB:TTL_LSB]       <= header_pkt_send[TTL_MSB:TTL_LSB];
          hdr_cap_p0[PKTNUM_MSB:PKTNUM_LSB] <= header_pkt_send[PKTNUM_MSB:PKTNUM_LSB];
          hdr_cap_p0[SRC_MSB:SRC_LSB]       <= header_pkt_send[SRC_MSB:SRC_LSB];
          dst_cap_p0                        <= router_dst_addr_send;
          state                             <= ST_HDR;
        end
        ST_HDR: begin
          if (!fifo_almost_full) begin
            wr_input_port_0   <= 1'b1;
            data_input_port_0 <= hdr_word;
            state             <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (pay_accept) begin
            wr_input_port_0   <= 1'b1;
            data_input_port_0 <= payload_data;
            word_cnt          <= word_cnt + CNT_W'(1);
            if (last_word) begin
`ifdef DFX_ENCAP_TAIL_EN
              state <= ST_TAIL;
`else
              state <= ST_DONE;
`endif
            end
          end
        end
`ifdef DFX_ENCAP_TAIL_EN
        ST_TAIL: begin
          if (!fifo_almost_full) begin
            wr_input_port_0   <= 1'b1;
            data_input_port_0 <= tail_word;
            state             <= ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          pkt_done   <= 1'b1;
          word_cnt   <= '0;
          encap_busy <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          encap_busy <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dfx_pkt_encap.sv
// Directed bench for dfx_pkt_encap: expected FIFO words are queued as each
// packet is set up and compared as the DUT writes them.
module tb_dfx_pkt_encap;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int NP = 16;
`ifdef DFX_ENCAP_TAIL_EN
  localparam bit TAIL_EN = 1'b1;
`else
  localparam bit TAIL_EN = 1'b0;
`endif
  localparam int NW = NP + 1 + (TAIL_EN ? 1 : 0);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dfx_start = 1'b0;
  logic          ready_encap_dfx;
  logic [8:0]    header_pkt_send = '0;
  logic [AW-1:0] router_dst_addr_send = '0;
  logic          payload_valid = 1'b0;
  logic [DW-1:0] payload_data = '0;
  logic          payload_ready;
  logic          fifo_almost_full = 1'b0;
  logic          wr_input_port_0;
  logic [DW-1:0] data_input_port_0;
  logic          encap_busy;
  logic          pkt_done;

  dfx_pkt_encap #(
    .AURORA_DATA_WIDTH (DW),
    .ADDR_WIDTH        (AW),
    .PAYLOAD_WORDS     (NP)
  ) dut (
    .clk                  (clk),
    .rst                  (rst),
    .dfx_start            (dfx_start),
    .ready_encap_dfx      (ready_encap_dfx),
    .header_pkt_send      (header_pkt_send),
    .router_dst_addr_send (router_dst_addr_send),
    .payload_valid        (payload_valid),
    .payload_data         (payload_data),
    .payload_ready        (payload_ready),
    .fifo_almost_full     (fifo_almost_full),
    .wr_input_port_0      (wr_input_port_0),
    .data_input_port_0    (data_input_port_0),
    .encap_busy           (encap_busy),
    .pkt_done             (pkt_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    bit          is_hdr;
    bit          is_last;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] src_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int rdy_cnt = 0;
  int done_cnt = 0;
  int last_wr_cyc = -100;
  bit last_was_final = 1'b0;
  bit check_gap = 1'b0;
  bit fif_toggle = 1'b0;
  bit vld_toggle = 1'b0;
  bit vld_gate = 1'b1;
  bit prev_rdy = 1'b0;
  bit prev_rst = 1'b1;
  logic [63:0] last_data = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] hdr_of(input logic [8:0] h, input logic [AW-1:0] d);
    return {16'h0, 16'(NP), 13'h0, d, h};
  endfunction

  // Sets the controller-side header inputs and queues the packet's expected words.
  task automatic setup_pkt(input logic [8:0] h, input logic [AW-1:0] d,
                           input logic [63:0] hexp, input logic [63:0] base);
    logic [63:0] x;
    logic [63:0] w;
    header_pkt_send      = h;
    router_dst_addr_send = d;
    exp_q.push_back('{hexp, 1'b1, 1'b0});
    x = '0;
    for (int i = 1; i <= NP; i++) begin
      w = base + 64'(i);
      src_q.push_back(w);
      x = x ^ w;
      exp_q.push_back('{w, 1'b0, (i == NP) && !TAIL_EN});
    end
    if (TAIL_EN) exp_q.push_back('{{x[63:9], h}, 1'b0, 1'b1});
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    dfx_start = 1'b1;
    @(posedge clk); #1;
    dfx_start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int limit);
    int n = 0;
    while (done_cnt < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("pkt_done_reached", 64'(done_cnt >= target), 64'd1);
  endtask

  task automatic wait_wr(input int target, input int limit);
    int n = 0;
    while (wr_cnt < target && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    chk("writes_reached", 64'(wr_cnt >= target), 64'd1);
  endtask

  task automatic chk_outputs_zero();
    chk("rst_ready_encap_dfx", 64'(ready_encap_dfx), 64'd0);
    chk("rst_wr", 64'(wr_input_port_0), 64'd0);
    chk("rst_data", data_input_port_0, 64'd0);
    chk("rst_busy", 64'(encap_busy), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_payload_ready", 64'(payload_ready), 64'd0);
  endtask

  // Payload source: consumes a word only when the DUT showed payload_ready.
  initial begin
    bit take;
    forever begin
      @(negedge clk);
      take = payload_ready;
      @(posedge clk); #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      fifo_almost_full = fif_toggle ? ~fifo_almost_full : 1'b0;
      vld_gate         = vld_toggle ? ~vld_gate : 1'b1;
      payload_valid    = (src_q.size() > 0) && vld_gate;
      payload_data     = (src_q.size() > 0) ? src_q[0] : '0;
    end
  end

  // FIFO-side monitor and scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (ready_encap_dfx) begin
        rdy_cnt++;
        chk("rdy_single_cycle", 64'(prev_rdy), 64'd0);
      end
      prev_rdy = ready_encap_dfx;
      if (wr_input_port_0) begin
        chk("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          if (e.is_hdr) begin
            chk("hdr_word", data_input_port_0, e.data);
            if (check_gap) chk("btb_gap", 64'(cyc - last_wr_cyc), 64'd5);
          end else begin
            chk("data_word", data_input_port_0, e.data);
          end
          last_was_final = e.is_last;
        end
        last_wr_cyc = cyc;
        wr_cnt++;
      end else if (!prev_rst) begin
        chk("data_hold", data_input_port_0, last_data);
      end
      last_data = data_input_port_0;
      if (pkt_done) begin
        done_cnt++;
        chk("pkt_done_timing", 64'(cyc - last_wr_cyc), 64'd1);
        chk("pkt_done_after_last", 64'(last_was_final), 64'd1);
      end
      prev_rst = rst;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, rb, db, lat;
    bit seen;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk_outputs_zero();
    @(posedge clk); #1;
    rst = 1'b0;

    // Packet 1: reference header, payload 1..16, latency from dfx_start
    wb = wr_cnt; rb = rdy_cnt;
    setup_pkt(9'h10A, 10'h155, 64'h0000_0010_0002_AB0A, 64'd0);
    @(posedge clk); #1;
    dfx_start = 1'b1;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (wr_input_port_0) seen = 1'b1;
      else begin
        lat++;
        @(posedge clk); #1;
        dfx_start = 1'b0;
      end
    end
    chk("hdr_latency", 64'(lat), 64'd4);
    wait_done(1, 100);
    chk("pkt1_writes", 64'(wr_cnt - wb), 64'(NW));
    chk("pkt1_rdy_pulses", 64'(rdy_cnt - rb), 64'd1);
    chk("pkt1_queue_empty", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk); #1;
    chk("idle_busy", 64'(encap_busy), 64'd0);

    // Packet 2: FIFO almost-full toggling every cycle
    wb = wr_cnt;
    fif_toggle = 1'b1;
    setup_pkt(9'h0C5, 10'h2A3, hdr_of(9'h0C5, 10'h2A3), 64'h1111_0000_0000_0000);
    pulse_start();
    wait_done(2, 300);
    fif_toggle = 1'b0;
    chk("pkt2_writes", 64'(wr_cnt - wb), 64'(NW));
    chk("pkt2_queue_empty", 64'(exp_q.size()), 64'd0);

    // Packet 3: payload_valid toggling, extra dfx_start mid-packet is ignored
    wb = wr_cnt; rb = rdy_cnt;
    vld_toggle = 1'b1;
    setup_pkt(9'h1F3, 10'h0AA, hdr_of(9'h1F3, 10'h0AA), 64'hDEAD_BEEF_0000_0100);
    pulse_start();
    wait_wr(wb + 3, 50);
    chk("busy_in_pay", 64'(encap_busy), 64'd1);
    pulse_start();
    wait_done(3, 300);
    repeat (12) @(negedge clk); #1;
    vld_toggle = 1'b0;
    chk("pkt3_writes", 64'(wr_cnt - wb), 64'(NW));
    chk("pkt3_rdy_pulses", 64'(rdy_cnt - rb), 64'd1);
    chk("pkt3_done_count", 64'(done_cnt), 64'd3);

    // Packet 4: reset at the 5th payload word aborts it
    wb = wr_cnt; db = done_cnt;
    setup_pkt(9'h055, 10'h3C3, hdr_of(9'h055, 10'h3C3), 64'h0F0F_0000_0000_0000);
    pulse_start();
    wait_wr(wb + 6, 100);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk); #1;
    chk_outputs_zero();
    exp_q.delete();
    src_q.delete();
    wb = wr_cnt;
    repeat (10) @(negedge clk); #1;
    chk("no_write_after_rst", 64'(wr_cnt - wb), 64'd0);
    chk("no_done_after_rst", 64'(done_cnt - db), 64'd0);

    // Packet 5: full packet after the abort
    wb = wr_cnt;
    setup_pkt(9'h0A7, 10'h101, hdr_of(9'h0A7, 10'h101), 64'h0000_5555_0000_0000);
    pulse_start();
    wait_done(db + 1, 100);
    chk("pkt5_writes", 64'(wr_cnt - wb), 64'(NW));
    chk("pkt5_queue_empty", 64'(exp_q.size()), 64'd0);

    // Packets 6-8: dfx_start held high, back-to-back framing
    wb = wr_cnt; rb = rdy_cnt; db = done_cnt;
    for (int p = 0; p < 3; p++)
      setup_pkt(9'h16C, 10'h2D2, hdr_of(9'h16C, 10'h2D2), 64'(p + 1) << 40);
    @(posedge clk); #1;
    dfx_start = 1'b1;
    wait_wr(wb + 1, 20);
    check_gap = 1'b1;
    lat = 0;
    while (rdy_cnt < rb + 3 && lat < 200) begin
      @(negedge clk); #1;
      lat++;
    end
    @(posedge clk); #1;
    dfx_start = 1'b0;
    wait_done(db + 3, 200);
    check_gap = 1'b0;
    repeat (8) @(negedge clk); #1;
    chk("btb_rdy_pulses", 64'(rdy_cnt - rb), 64'd3);
    chk("btb_writes", 64'(wr_cnt - wb), 64'(3 * NW));
    chk("btb_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
